// File: rtl/rv_writeback_lsq_pkg.sv
// Shared definitions for the writeback stage: load/store function codes and
// the load-queue entry layout.
package rv_writeback_lsq_pkg;

    // Load/store width codes (funct3 encoding)
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // One queued load: destination, width code, byte offset (5+3+2 bits)
    localparam int unsigned LQ_ENTRY_W = 10;

    // Store counter width, sized for the largest supported SQ_DEPTH (15)
    localparam int unsigned SQ_CNT_W = 4;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] fun;
        logic [1:0] ofs;
    } lq_entry_t;

endpackage

// File: rtl/rv_wb_load_queue.sv
// In-order FIFO of outstanding loads with per-entry destination-register
// compare vectors (source hazard and write-after-write detection).
module rv_wb_load_queue
    import rv_writeback_lsq_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2,
    parameter int unsigned CNT_W    = $clog2(LQ_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                push_i,
    input  lq_entry_t           push_entry_i,
    input  logic                pop_i,
    output lq_entry_t           head_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                full_o,
    output logic                empty_o,
    input  logic [4:0]          cmp_rs1_i,
    input  logic [4:0]          cmp_rs2_i,
    input  logic [4:0]          cmp_rd_i,
    output logic [LQ_DEPTH-1:0] hit_rs1_o,
    output logic [LQ_DEPTH-1:0] hit_rs2_o,
    output logic [LQ_DEPTH-1:0] hit_rd_o
);

    localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    logic [LQ_ENTRY_W-1:0] mem_q [LQ_DEPTH];
    logic [LQ_ENTRY_W-1:0] mem_d [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;
    lq_entry_t             cur;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(LQ_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_entry_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Per-entry register compares; an entry counts until it is popped
    always_comb begin
        hit_rs1_o = '0;
        hit_rs2_o = '0;
        hit_rd_o  = '0;
        cur       = '0;
        for (int i = 0; i < int'(LQ_DEPTH); i++) begin
            cur = mem_q[i];
            if (valid_q[i] && (cur.rd != 5'd0)) begin
                hit_rs1_o[i] = (cur.rd == cmp_rs1_i);
                hit_rs2_o[i] = (cur.rd == cmp_rs2_i);
                hit_rd_o[i]  = (cur.rd == cmp_rd_i);
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '{default: '0};
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rv_writeback_lsq.sv
// Writeback stage: outstanding-load queue, store counter, load alignment and
// register-file write arbitration (load completions win over ALU results).
// Optional feature macro: URV_WB_MISALIGN_TRAP_EN (drop misaligned loads and
// pulse w_misalign_o).
module rv_writeback_lsq
    import rv_writeback_lsq_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2,
    parameter int unsigned SQ_DEPTH = 2,
    parameter int unsigned CNT_W    = $clog2(LQ_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             w_stall_i,
    output logic             w_stall_req_o,
    input  logic             x_valid_i,
    input  logic [2:0]       x_fun_i,
    input  logic             x_load_i,
    input  logic             x_store_i,
    input  logic [31:0]      x_dm_addr_i,
    input  logic [4:0]       x_rd_i,
    input  logic [31:0]      x_rd_value_i,
    input  logic             x_rd_write_i,
    input  logic [4:0]       x_rs1_i,
    input  logic [4:0]       x_rs2_i,
    input  logic [31:0]      dm_data_l_i,
    input  logic             dm_load_done_i,
    input  logic             dm_store_done_i,
    output logic [31:0]      rf_rd_value_o,
    output logic [4:0]       rf_rd_o,
    output logic             rf_rd_write_o,
    output logic             w_hazard_o,
    output logic [CNT_W-1:0] lq_count_o,
    output logic             w_misalign_o
);

    lq_entry_t             head, push_entry;
    logic                  lq_full, lq_empty;
    logic [CNT_W-1:0]      lq_count;
    logic [LQ_DEPTH-1:0]   hit_rs1, hit_rs2, hit_rd;
    logic [SQ_CNT_W-1:0]   sq_cnt_q, sq_cnt_d;
    logic                  ldone, alu_req, stall_req, fire;
    logic                  push, misalign, sq_inc, sq_dec, rf_we;
    logic                  addr_unused;

    assign addr_unused = ^x_dm_addr_i[31:2];

    // Select and extend the addressed byte/half of returning load data
    function automatic logic [31:0] align_load(input logic [2:0]  fun,
                                               input logic [1:0]  ofs,
                                               input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(data >> {ofs, 3'b000});
        h = 16'(data >> {ofs[1], 4'b0000});
        case (fun)
            LDST_B:  return {{24{b[7]}}, b};
            LDST_BU: return {24'd0, b};
            LDST_H:  return {{16{h[15]}}, h};
            LDST_HU: return {16'd0, h};
            LDST_W:  return data;
            default: return data;
        endcase
    endfunction

`ifdef URV_WB_MISALIGN_TRAP_EN
    // Halfword at an odd address or word not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [2:0] fun,
                                           input logic [1:0] ofs);
        return (((fun == LDST_H) || (fun == LDST_HU)) && ofs[0])
            || ((fun == LDST_W) && (ofs != 2'd0));
    endfunction
`endif

    rv_wb_load_queue #(
        .LQ_DEPTH (LQ_DEPTH),
        .CNT_W    (CNT_W)
    ) u_lq (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (ldone),
        .head_o       (head),
        .count_o      (lq_count),
        .full_o       (lq_full),
        .empty_o      (lq_empty),
        .cmp_rs1_i    (x_rs1_i),
        .cmp_rs2_i    (x_rs2_i),
        .cmp_rd_i     (x_rd_i),
        .hit_rs1_o    (hit_rs1),
        .hit_rs2_o    (hit_rs2),
        .hit_rd_o     (hit_rd)
    );

    // Stall sources, issue qualification and queue push
    always_comb begin
        ldone      = dm_load_done_i && !lq_empty;
        alu_req    = x_valid_i && x_rd_write_i && !x_load_i && !x_store_i;
        stall_req  = (x_valid_i && x_load_i && lq_full)
                  || (x_valid_i && x_store_i && (sq_cnt_q == SQ_CNT_W'(SQ_DEPTH)))
                  || (alu_req && ldone)
                  || (alu_req && (|hit_rd));
        fire       = x_valid_i && !w_stall_i && !stall_req;
`ifdef URV_WB_MISALIGN_TRAP_EN
        misalign   = fire && x_load_i && is_misaligned(x_fun_i, x_dm_addr_i[1:0]);
`else
        misalign   = 1'b0;
`endif
        push       = fire && x_load_i && !misalign;
        push_entry = '{rd: x_rd_i, fun: x_fun_i, ofs: x_dm_addr_i[1:0]};
    end

    // Store counter next state; simultaneous issue and completion cancel
    always_comb begin
        sq_cnt_d = sq_cnt_q;
        sq_inc   = fire && x_store_i;
        sq_dec   = dm_store_done_i && (sq_cnt_q != '0);
        if (sq_inc && !sq_dec) begin
            sq_cnt_d = sq_cnt_q + SQ_CNT_W'(1);
        end else if (sq_dec && !sq_inc) begin
            sq_cnt_d = sq_cnt_q - SQ_CNT_W'(1);
        end
    end

    // Register-file write port: load completion first, then ALU result
    always_comb begin
        rf_rd_o       = x_rd_i;
        rf_rd_value_o = x_rd_value_i;
        rf_we         = fire && alu_req && (x_rd_i != 5'd0);
        if (ldone) begin
            rf_rd_o       = head.rd;
            rf_rd_value_o = align_load(head.fun, head.ofs, dm_data_l_i);
            rf_we         = (head.rd != 5'd0);
        end
    end

    // Status outputs are forced low while reset is asserted
    assign rf_rd_write_o = rst_n_i && rf_we;
    assign w_stall_req_o = rst_n_i && stall_req;
    assign w_hazard_o    = rst_n_i && (|(hit_rs1 | hit_rs2));
    assign w_misalign_o  = rst_n_i && misalign;
    assign lq_count_o    = lq_count;

    // Outstanding store counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sq_cnt_q <= '0;
        end else begin
            sq_cnt_q <= sq_cnt_d;
        end
    end

endmodule

// File: tb/tb_rv_writeback_lsq.sv
// Scoreboard bench for rv_writeback_lsq: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_rv_writeback_lsq;

    localparam int unsigned LQ_DEPTH = 2;
    localparam int unsigned SQ_DEPTH = 2;
    localparam int unsigned CNT_W    = $clog2(LQ_DEPTH + 1);

    localparam bit [2:0] F_LB = 3'd0, F_LH = 3'd1, F_LW = 3'd2, F_LBU = 3'd4, F_LHU = 3'd5;

    logic             clk_i, rst_n_i, w_stall_i, w_stall_req_o;
    logic             x_valid_i, x_load_i, x_store_i, x_rd_write_i;
    logic [2:0]       x_fun_i;
    logic [31:0]      x_dm_addr_i, x_rd_value_i, dm_data_l_i, rf_rd_value_o;
    logic [4:0]       x_rd_i, x_rs1_i, x_rs2_i, rf_rd_o;
    logic             dm_load_done_i, dm_store_done_i, rf_rd_write_o, w_hazard_o, w_misalign_o;
    logic [CNT_W-1:0] lq_count_o;

    rv_writeback_lsq #(.LQ_DEPTH(LQ_DEPTH), .SQ_DEPTH(SQ_DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .w_stall_i(w_stall_i), .w_stall_req_o(w_stall_req_o),
        .x_valid_i(x_valid_i), .x_fun_i(x_fun_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
        .x_dm_addr_i(x_dm_addr_i), .x_rd_i(x_rd_i), .x_rd_value_i(x_rd_value_i),
        .x_rd_write_i(x_rd_write_i), .x_rs1_i(x_rs1_i), .x_rs2_i(x_rs2_i),
        .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i),
        .dm_store_done_i(dm_store_done_i), .rf_rd_value_o(rf_rd_value_o), .rf_rd_o(rf_rd_o),
        .rf_rd_write_o(rf_rd_write_o), .w_hazard_o(w_hazard_o), .lq_count_o(lq_count_o),
        .w_misalign_o(w_misalign_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        valid, load, store, rdw, ld_done, st_done, wstall;
        bit [2:0]  fun;
        bit [31:0] addr, val, dm;
        bit [4:0]  rd, rs1, rs2;
    } stim_t;

    typedef struct { bit [4:0] rd; bit [2:0] fun; bit [1:0] ofs; } mentry_t;
    typedef struct { bit we; bit [4:0] rd; bit [31:0] val; } wr_t;

    mentry_t m_lq[$];
    int      m_sq;
    wr_t     exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected register value for a load of the given width/offset
    function automatic bit [31:0] ref_load(input bit [2:0] fun, input bit [1:0] ofs, input bit [31:0] d);
        bit [31:0] t = d >> (8 * ofs);
        bit [31:0] u = d >> (16 * ofs[1]);
        bit [7:0]  b = t[7:0];
        bit [15:0] h = u[15:0];
        case (fun)
            F_LB:    return 32'(signed'(b));
            F_LH:    return 32'(signed'(h));
            F_LBU:   return 32'(b);
            F_LHU:   return 32'(h);
            default: return d;
        endcase
    endfunction

    function automatic bit ref_misaligned(input bit [2:0] fun, input bit [1:0] ofs);
`ifdef URV_WB_MISALIGN_TRAP_EN
        return ((fun == F_LH || fun == F_LHU) && ofs[0]) || (fun == F_LW && ofs != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t mk_load(input bit [2:0] fun, input bit [4:0] rd, input bit [31:0] addr);
        stim_t s = idle();
        s.valid = 1; s.load = 1; s.fun = fun; s.rd = rd; s.addr = addr;
        return s;
    endfunction

    function automatic stim_t mk_alu(input bit [4:0] rd, input bit [31:0] val);
        stim_t s = idle();
        s.valid = 1; s.rdw = 1; s.rd = rd; s.val = val;
        return s;
    endfunction

    function automatic stim_t mk_store();
        stim_t s = idle();
        s.valid = 1; s.store = 1; s.fun = F_LW; s.addr = $urandom;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        x_valid_i = s.valid;  x_fun_i = s.fun;  x_load_i = s.load;  x_store_i = s.store;
        x_dm_addr_i = s.addr; x_rd_i = s.rd;   x_rd_value_i = s.val; x_rd_write_i = s.rdw;
        x_rs1_i = s.rs1;      x_rs2_i = s.rs2; dm_data_l_i = s.dm;
        dm_load_done_i = s.ld_done; dm_store_done_i = s.st_done; w_stall_i = s.wstall;
    endtask

    // One cycle: apply stimulus, predict from the model, check, advance model
    task automatic step(input stim_t s, output bit fired);
        bit ldone, alu, waw, haz, stall, mis;
        wr_t e;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(s);
        #1;
        ldone = s.ld_done && (m_lq.size() > 0);
        alu   = s.valid && s.rdw && !s.load && !s.store;
        waw   = 0;
        haz   = 0;
        foreach (m_lq[i]) begin
            if (m_lq[i].rd != 0 && m_lq[i].rd == s.rd) waw = 1;
            if (m_lq[i].rd != 0 && (m_lq[i].rd == s.rs1 || m_lq[i].rd == s.rs2)) haz = 1;
        end
        stall = (s.valid && s.load && m_lq.size() == LQ_DEPTH)
             || (s.valid && s.store && m_sq == SQ_DEPTH)
             || (alu && ldone) || (alu && waw);
        fired = s.valid && !s.wstall && !stall;
        mis   = fired && s.load && ref_misaligned(s.fun, s.addr[1:0]);
        check("stall_req", w_stall_req_o, stall);
        check("hazard", w_hazard_o, haz);
        check("lq_count", lq_count_o, m_lq.size());
        check("misalign", w_misalign_o, mis);
        e = '{default: 0};
        if (ldone) begin
            e.we = (m_lq[0].rd != 0); e.rd = m_lq[0].rd;
            e.val = ref_load(m_lq[0].fun, m_lq[0].ofs, s.dm);
        end else if (fired && alu && s.rd != 0) begin
            e.we = 1; e.rd = s.rd; e.val = s.val;
        end
        exp_q.push_back(e);
        if (ldone) void'(m_lq.pop_front());
        if (fired && s.load && !mis) m_lq.push_back('{rd: s.rd, fun: s.fun, ofs: s.addr[1:0]});
        if (fired && s.store && !(s.st_done && m_sq > 0)) m_sq++;
        else if (!(fired && s.store) && s.st_done && m_sq > 0) m_sq--;
    endtask

    // Two cycles of reset with busy inputs; everything must read zero
    task automatic reset_dut();
        stim_t s = mk_alu(9, 32'h5A5A_5A5A);
        s.ld_done = 1; s.st_done = 1; s.rs1 = 10; s.rs2 = 11; s.dm = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            rst_n_i = 1'b0;
            drive(s);
            #1;
            check("rst_we", rf_rd_write_o, 0);
            check("rst_stall", w_stall_req_o, 0);
            check("rst_hazard", w_hazard_o, 0);
            check("rst_misalign", w_misalign_o, 0);
            check("rst_count", lq_count_o, 0);
            exp_q.push_back('{default: 0});
        end
        m_lq.delete();
        m_sq = 0;
    endtask

    task automatic drain();
        stim_t s;
        bit f;
        for (int i = 0; i < 40 && (m_lq.size() > 0 || m_sq > 0); i++) begin
            s = idle(); s.ld_done = 1; s.st_done = 1; s.dm = $urandom;
            step(s, f);
        end
        if (m_lq.size() > 0 || m_sq > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: queue not empty after cycle budget");
        end
    endtask

    function automatic stim_t gen();
        stim_t s;
        bit [2:0] funs[5] = '{F_LB, F_LH, F_LW, F_LBU, F_LHU};
        int k = $urandom % 8;
        if (k < 3)      s = mk_load(funs[$urandom % 5], 5'($urandom % 8), $urandom);
        else if (k < 5) s = mk_store();
        else if (k < 7) s = mk_alu(5'($urandom % 8), $urandom);
        else            s = idle();
        return s;
    endfunction

    // Monitor: compare every register-file write against the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we", rf_rd_write_o, e.we);
                if (e.we) begin
                    check("rf_rd", rf_rd_o, e.rd);
                    check("rf_value", rf_rd_value_o, e.val);
                end
            end else if (rf_rd_write_o === 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL rf_unexpected: write to x%0d with no expectation", rf_rd_o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, cur;
        bit f;
        rst_n_i = 1'b0;
        drive(idle());
        m_sq = 0;
        reset_dut();

        // Three back-to-back LW, queue holds two
        s = mk_load(F_LW, 5, 0); step(s, f);
        s.rd = 6;                step(s, f);
        s.rd = 7;                step(s, f);
        check("tp1_count_full", lq_count_o, 2);
        check("tp1_stall_third", w_stall_req_o, 1);
        s.ld_done = 1; s.dm = 32'h11; step(s, f);
        check("tp1_x5_rd", rf_rd_o, 5);
        check("tp1_x5_val", rf_rd_value_o, 32'h11);
        check("tp1_stall_hold", w_stall_req_o, 1);
        s.dm = 32'h22; step(s, f);
        check("tp1_x6_rd", rf_rd_o, 6);
        check("tp1_x6_val", rf_rd_value_o, 32'h22);
        check("tp1_third_push", w_stall_req_o, 0);
        drain();

        // Byte/half alignment and extension
        step(mk_load(F_LB, 8, 32'h1003), f);
        s = idle(); s.ld_done = 1; s.dm = 32'h80FF_FF7F; step(s, f);
        check("lb_sext", rf_rd_value_o, 32'hFFFF_FF80);
        step(mk_load(F_LBU, 8, 32'h1003), f);
        step(s, f);
        check("lbu_zext", rf_rd_value_o, 32'h0000_0080);
        step(mk_load(F_LHU, 8, 32'h1002), f);
        step(s, f);
        check("lhu_upper", rf_rd_value_o, 32'h0000_80FF);

        // ALU write colliding with a load completion retries next cycle
        step(mk_load(F_LW, 3, 0), f);
        s = mk_alu(9, 32'h1234); s.ld_done = 1; s.dm = 32'hCAFE_0003; step(s, f);
        check("col_load_rd", rf_rd_o, 3);
        check("col_stall", w_stall_req_o, 1);
        s.ld_done = 0; step(s, f);
        check("col_alu_rd", rf_rd_o, 9);
        check("col_alu_val", rf_rd_value_o, 32'h1234);

        // RAW hazard flag and WAW stall on x4
        step(mk_load(F_LW, 4, 0), f);
        s = idle(); s.rs2 = 4; step(s, f);
        check("haz_pending", w_hazard_o, 1);
        s = mk_alu(4, 32'h55); s.rs2 = 4; step(s, f);
        check("waw_stall", w_stall_req_o, 1);
        check("waw_no_write", rf_rd_write_o, 0);
        s.ld_done = 1; s.dm = 32'h4444; step(s, f);
        check("waw_load_val", rf_rd_value_o, 32'h4444);
        check("haz_pop_cycle", w_hazard_o, 1);
        s.ld_done = 0; step(s, f);
        check("haz_cleared", w_hazard_o, 0);
        check("waw_final_val", rf_rd_value_o, 32'h55);
        check("waw_final_we", rf_rd_write_o, 1);

        // Reset in the middle of traffic, then a stray completion
        step(mk_load(F_LW, 10, 0), f);
        step(mk_load(F_LW, 11, 0), f);
        step(mk_store(), f);
        check("mid_count", lq_count_o, 2);
        reset_dut();
        s = idle(); s.ld_done = 1; s.st_done = 1; s.dm = 32'hDEAD_BEEF; step(s, f);
        check("stray_no_write", rf_rd_write_o, 0);

`ifdef URV_WB_MISALIGN_TRAP_EN
        step(mk_load(F_LH, 12, 32'h2001), f);
        check("mis_pulse", w_misalign_o, 1);
        step(idle(), f);
        check("mis_no_push", lq_count_o, 0);
        check("mis_pulse_end", w_misalign_o, 0);
`endif

        // Randomized traffic; an instruction is held until it fires
        cur = gen();
        for (int n = 0; n < 3000; n++) begin
            s = cur;
            s.ld_done = ($urandom % 3) == 0;
            s.st_done = ($urandom % 3) == 0;
            s.wstall  = ($urandom % 8) == 0;
            s.dm      = $urandom;
            s.rs1     = 5'($urandom % 8);
            s.rs2     = 5'($urandom % 8);
            step(s, f);
            if (f || !cur.valid) cur = gen();
        end
        drain();
        step(idle(), f);
        repeat (2) @(negedge clk_i);
        #3;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_writeback_lsq.md
Name: rv_writeback_lsq

Overview:
Writeback stage with a parametrised outstanding-load queue and store counter.
- Lets the execute stage issue up to LQ_DEPTH loads and SQ_DEPTH stores without stalling.
- Aligns and sign-extends returning load data.
- Arbitrates register-file writes between load completions and ALU results.
- Exports a RAW hazard flag against in-flight load destinations.
- Sits between the execute stage / data-memory interface and the register file.

Parameters:
LQ_DEPTH, 2, outstanding load entries; power of two, 1..8
SQ_DEPTH, 2, outstanding stores; 1..15
CNT_W, $clog2(LQ_DEPTH+1), width of lq_count_o

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
w_stall_i  in  1  writeback stalled by downstream/global stall
w_stall_req_o  out  1  writeback requests pipeline stall
x_valid_i  in  1  execute-stage instruction valid
x_fun_i  in  3  LDST_* function code
x_load_i  in  1  instruction is a load
x_store_i  in  1  instruction is a store
x_dm_addr_i  in  32  data-memory address (bits [1:0] used)
x_rd_i  in  5  destination register
x_rd_value_i  in  32  ALU result
x_rd_write_i  in  1  ALU result writes rd
x_rs1_i  in  5  source register 1 of the instruction in decode
x_rs2_i  in  5  source register 2 of the instruction in decode
dm_data_l_i  in  32  load data, valid with dm_load_done_i
dm_load_done_i  in  1  oldest load completes (1-cycle pulse)
dm_store_done_i  in  1  oldest store completes (1-cycle pulse)
rf_rd_value_o  out  32  register-file write data
rf_rd_o  out  5  register-file write index
rf_rd_write_o  out  1  register-file write enable
w_hazard_o  out  1  rs1/rs2 matches a pending load rd
lq_count_o  out  CNT_W  occupied load-queue entries
w_misalign_o  out  1  misaligned-load pulse (macro only; tied 0 otherwise)

Behaviour:
Definitions:
- Fire = x_valid_i && !w_stall_i && !w_stall_req_o.
- Ldone = dm_load_done_i && queue non-empty.

Reset (async, rst_n_i=0):
- Queue empty, store count 0, lq_count_o=0.
- rf_rd_write_o, w_stall_req_o, w_hazard_o, w_misalign_o all 0, regardless of other inputs.

Load issue:
- On fire && x_load_i, push {x_rd_i, x_fun_i, x_dm_addr_i[1:0]} at the posedge.
- Queue full (count==LQ_DEPTH) with x_valid_i && x_load_i: w_stall_req_o=1, no push.

Load completion:
- On Ldone, the head is popped at the posedge.
- Same cycle, combinationally: rf_rd_o=head.rd, rf_rd_value_o=aligned data, rf_rd_write_o=(head.rd!=0).
- Alignment:
  - B/BU: byte at addr[1:0], sign- or zero-extended.
  - H/HU: half selected by addr[1], sign- or zero-extended.
  - W: full word.
- dm_load_done_i with an empty queue is ignored; no write.
- Push and pop in the same cycle: count unchanged. When full, a pop does not free the slot in that same cycle; the stall holds one more cycle.

ALU writeback:
- When x_valid_i && x_rd_write_i && !x_load_i && !x_store_i, write x_rd_value_i to x_rd_i (index 0 suppressed). This happens only when not stalled and there is no Ldone that cycle.
- Ldone has priority. A colliding ALU write raises w_stall_req_o and retries the next cycle.
- WAW: if x_rd_i (non-zero) matches any valid queue entry rd, assert w_stall_req_o until that entry retires.

Stores:
- Counter increments on fire && x_store_i and decrements on dm_store_done_i; simultaneous events leave it unchanged.
- Count==SQ_DEPTH with x_valid_i && x_store_i: stall.
- dm_store_done_i at count 0 is ignored.

Hazard:
- w_hazard_o=1 if any valid entry has rd!=0 equal to x_rs1_i or x_rs2_i.
- The entry being popped this cycle still counts (its data is not yet in the RF).

w_stall_i=1:
- No push and no ALU write.
- Load completions are still accepted and written; memory cannot be held off.

Optional Feature:
URV_WB_MISALIGN_TRAP_EN:
- Defined: a load with H/HU at addr[0]=1, or W at addr[1:0]!=0, is not pushed. w_misalign_o pulses for one cycle on that fire; no RF write occurs.
- Undefined: the low address bits are ignored as described in Behaviour, and w_misalign_o is tied 0.

Decomposition:
- LDST_* function codes stay in the shared rv_defs.v.
- Add a shared LQ entry width constant (5+3+2=10 bits).
- One sub-module, rv_wb_load_queue: a FIFO of LQ_DEPTH entries with a per-entry rd compare vector (used for both the hazard flag and the WAW check).
- The aligner is a function inside rv_writeback_lsq.

Test Plan:
- Three back-to-back LW to x5,x6,x7 with LQ_DEPTH=2, dm_load_done_i withheld:
  - First two push (lq_count_o=2), third raises w_stall_req_o.
  - Two done pulses with data 0x11,0x22 write x5=0x11, x6=0x22 in order; third then pushes.
- LB addr[1:0]=3 with data 0x80FF_FF7F: rf_rd_value_o=0xFFFF_FF80. LBU with the same data: 0x0000_0080. LHU addr=2: 0x0000_80FF.
- ALU write x9=0x1234 in the same cycle as a load completion to x3:
  - Cycle N writes x3 with w_stall_req_o=1.
  - Cycle N+1 writes x9=0x1234.
- Pending LW to x4, decode rs2=4: w_hazard_o=1 until the cycle after done. Then ALU write to x4: stalled until the load retires, then the final x4 = ALU value.
- Assert rst_n_i mid-queue (count 2, store count 1): all outputs 0 immediately. A stray dm_load_done_i after release produces no write.
- Macro defined, LH addr=1: w_misalign_o=1 for one cycle, lq_count_o unchanged, no RF write.
